// File: rtl/round_seq_ctl_pkg.sv
// Shared types and constants for the duck-hunt round sequencer.
package round_seq_ctl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INTRO, S_LAUNCH, S_FLIGHT, S_REACT, S_ROUND_END, S_GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    REACT_NONE  = 2'd0,
    REACT_HOLD  = 2'd1,
    REACT_LAUGH = 2'd2
  } react_t;

  localparam logic [1:0] SHOTS_PER_DUCK = 2'd3;
endpackage

// File: rtl/round_seq_ctl_frame_timer.sv
// Counts frame ticks while enabled; done fires on the TERMINAL-th tick.
module frame_timer #(
  parameter int TERMINAL = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic tick,
  output logic done
);
  localparam int W = $clog2(TERMINAL + 1);

  logic [W-1:0] cnt;

  // Combinational done so the owning FSM can leave on the terminal tick itself.
  assign done = en && tick && (cnt == W'(TERMINAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (en && tick) cnt <= done ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/round_seq_ctl.sv
// Round/duck sequencer: intro, launch, flight, dog reaction, round scoring.
module round_seq_ctl
  import round_seq_ctl_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int MIN_HITS        = 6,
  parameter int FLIGHT_FRAMES   = 300,
  parameter int REACT_FRAMES    = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       frame_tick,
  input  logic       dog_intro_done,
  input  logic       shot_fired,
  input  logic       duck_hit,
  input  logic       duck_escaped,
  output logic       dog_start,
  output logic       duck_launch,
  output logic       fly_away,
  output logic [1:0] react_mode,
  output logic [1:0] shots_left,
  output logic [3:0] duck_index,
  output logic [3:0] hits,
  output logic [7:0] round_num,
  output logic       round_over,
  output logic       game_over
);
  state_t     state, state_n;
  react_t     react_q, react_n;
  logic       dog_start_n, duck_launch_n, fly_away_n, round_over_n, game_over_n;
  logic [1:0] shots_n;
  logic [3:0] idx_n, hits_n;
  logic [7:0] round_n;
  logic       flight_done, react_done;

  frame_timer #(.TERMINAL(FLIGHT_FRAMES)) u_flight_tmr (
    .clk(clk), .rst(rst), .clear(state != S_FLIGHT), .en(state == S_FLIGHT),
    .tick(frame_tick), .done(flight_done)
  );

  frame_timer #(.TERMINAL(REACT_FRAMES)) u_react_tmr (
    .clk(clk), .rst(rst), .clear(state != S_REACT), .en(state == S_REACT),
    .tick(frame_tick), .done(react_done)
  );

  // Outputs are computed alongside next-state and registered with it.
  always_comb begin
    state_n       = state;
    react_n       = react_q;
    shots_n       = shots_left;
    idx_n         = duck_index;
    hits_n        = hits;
    round_n       = round_num;
    dog_start_n   = 1'b0;
    duck_launch_n = 1'b0;
    fly_away_n    = 1'b0;
    round_over_n  = 1'b0;
    if (!game_enable) begin
      state_n = S_IDLE;
      react_n = REACT_NONE;
      shots_n = '0;
      idx_n   = '0;
      hits_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n     = S_INTRO;
          dog_start_n = 1'b1;
          round_n     = 8'd1;
          hits_n      = '0;
          idx_n       = '0;
        end
        S_INTRO: if (dog_intro_done) begin
          state_n       = S_LAUNCH;
          duck_launch_n = 1'b1;
          shots_n       = SHOTS_PER_DUCK;
        end
        S_LAUNCH: state_n = S_FLIGHT;
        S_FLIGHT: begin
          if (shot_fired && shots_left != 2'd0) shots_n = shots_left - 2'd1;
          if (duck_hit) begin
            state_n = S_REACT;
            react_n = REACT_HOLD;
            hits_n  = hits + 4'd1;
          end else if (duck_escaped) begin
            state_n = S_REACT;
            react_n = REACT_LAUGH;
          end else if (flight_done) begin
            state_n    = S_REACT;
            react_n    = REACT_LAUGH;
            fly_away_n = 1'b1;
          end
        end
        S_REACT: if (react_done) begin
          react_n = REACT_NONE;
          if (duck_index < 4'(DUCKS_PER_ROUND - 1)) begin
            idx_n         = duck_index + 4'd1;
            state_n       = S_LAUNCH;
            duck_launch_n = 1'b1;
            shots_n       = SHOTS_PER_DUCK;
          end else begin
            state_n = S_ROUND_END;
          end
        end
        S_ROUND_END: begin
          if (hits >= 4'(MIN_HITS)) begin
            round_over_n = 1'b1;
            if (round_num != 8'hFF) round_n = round_num + 8'd1;
            hits_n      = '0;
            idx_n       = '0;
            state_n     = S_INTRO;
            dog_start_n = 1'b1;
          end else begin
            state_n = S_GAME_OVER;
          end
        end
        S_GAME_OVER: state_n = S_GAME_OVER;
        default:     state_n = S_IDLE;
      endcase
    end
    game_over_n = (state_n == S_GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      react_q     <= REACT_NONE;
      shots_left  <= '0;
      duck_index  <= '0;
      hits        <= '0;
      round_num   <= '0;
      dog_start   <= 1'b0;
      duck_launch <= 1'b0;
      fly_away    <= 1'b0;
      round_over  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      react_q     <= react_n;
      shots_left  <= shots_n;
      duck_index  <= idx_n;
      hits        <= hits_n;
      round_num   <= round_n;
      dog_start   <= dog_start_n;
      duck_launch <= duck_launch_n;
      fly_away    <= fly_away_n;
      round_over  <= round_over_n;
      game_over   <= game_over_n;
    end
  end

  assign react_mode = react_q;
endmodule
